// File: rtl/sa_cache_fsm.sv
//------------------------------------------------------------------------------
// sa_cache_fsm
//
// N-way set-associative, write-back, write-allocate cache controller with
// internal tag/data storage. It sits between a blocking CPU request port and
// a line-oriented memory controller. A single request is outstanding at a
// time and runs through IDLE -> COMPARE_TAG -> (WRITE_BACK) -> ALLOCATE ->
// COMPARE_TAG -> IDLE.
//
// Optional build macro:
//   CACHE_STATS_EN  adds saturating 32-bit hit / miss / write-back counters.
//
// Ports:
//   clk             clock, rising edge
//   rst             synchronous, active-low reset
//   cpu_req_addr    CPU byte address
//   cpu_req_data    CPU write data
//   cpu_req_rw      1 = write, 0 = read
//   cpu_req_valid   request valid; held stable by the CPU until cpu_res_ready
//   cpu_res_data    read data, valid while cpu_res_ready = 1
//   cpu_res_ready   one-cycle completion pulse
//   mem_req_addr    line-aligned memory address
//   mem_req_data    write-back line
//   mem_req_rw      1 = write-back, 0 = line fill
//   mem_req_valid   memory request valid
//   mem_data_data   fill line from memory
//   mem_data_ready  one-cycle memory completion
//   stat_hits       (CACHE_STATS_EN) hits decided in COMPARE_TAG
//   stat_misses     (CACHE_STATS_EN) misses decided in COMPARE_TAG
//   stat_writebacks (CACHE_STATS_EN) dirty evictions started
//------------------------------------------------------------------------------
module sa_cache_fsm #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int WORDS  = 4,
    parameter int SETS   = 1024,
    parameter int WAYS   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          cpu_req_addr,
    input  logic [WORD_W-1:0]          cpu_req_data,
    input  logic                       cpu_req_rw,
    input  logic                       cpu_req_valid,
    output logic [WORD_W-1:0]          cpu_res_data,
    output logic                       cpu_res_ready,
    output logic [ADDR_W-1:0]          mem_req_addr,
    output logic [WORD_W*WORDS-1:0]    mem_req_data,
    output logic                       mem_req_rw,
    output logic                       mem_req_valid,
    input  logic [WORD_W*WORDS-1:0]    mem_data_data,
`ifdef CACHE_STATS_EN
    output logic [31:0]                stat_hits,
    output logic [31:0]                stat_misses,
    output logic [31:0]                stat_writebacks,
`endif
    input  logic                       mem_data_ready
);

    //--------------------------------------------------------------------------
    // Derived geometry
    //--------------------------------------------------------------------------
    localparam int LINE_W = WORD_W * WORDS;
    localparam int BYTE_W = $clog2(WORD_W / 8);
    localparam int OFF_W  = $clog2(WORDS) + BYTE_W;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    // Select widths are kept at least one bit wide so WORDS=1 / WAYS=1 still
    // elaborate; the single legal value is then 0.
    localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE_TAG,
        WRITE_BACK,
        ALLOCATE
    } state_t;

    state_t state, next_state;

    //--------------------------------------------------------------------------
    // Storage
    //--------------------------------------------------------------------------
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAY_W-1:0]  ptr_q   [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [LINE_W-1:0] line_q  [SETS][WAYS];

    // Victim captured at the miss decision; used by WRITE_BACK and ALLOCATE.
    logic [WAY_W-1:0]  vic_way_q;
    logic [TAG_W-1:0]  vic_tag_q;
    logic [LINE_W-1:0] vic_line_q;

    //--------------------------------------------------------------------------
    // Address split (request is held stable for the whole transaction)
    //--------------------------------------------------------------------------
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_word;

    assign req_tag  = cpu_req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx  = cpu_req_addr[OFF_W +: IDX_W];
    assign req_word = WSEL_W'((cpu_req_addr >> BYTE_W) % WORDS);

    //--------------------------------------------------------------------------
    // Set lookup: hit detection and victim choice
    //--------------------------------------------------------------------------
    logic [WAYS-1:0]   set_valid;
    logic [WAYS-1:0]   set_dirty;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              has_invalid;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  victim_way;
    logic              victim_dirty;
    logic [LINE_W-1:0] hit_line;
    logic [WORD_W-1:0] hit_word;
    logic [LINE_W-1:0] merged_line;

    assign set_valid = valid_q[req_idx];
    assign set_dirty = dirty_q[req_idx];

    // NOTE: every signal driven here gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        has_invalid = 1'b0;
        inv_way     = '0;
        // Walk downwards so the lowest-numbered matching / invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (set_valid[w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!set_valid[w]) begin
                has_invalid = 1'b1;
                inv_way     = WAY_W'(w);
            end
        end
    end

    assign victim_way   = has_invalid ? inv_way : ptr_q[req_idx];
    assign victim_dirty = set_valid[victim_way] && set_dirty[victim_way];

    assign hit_line = line_q[req_idx][hit_way];
    assign hit_word = hit_line[int'(req_word) * WORD_W +: WORD_W];

    always_comb begin
        merged_line = hit_line;
        merged_line[int'(req_word) * WORD_W +: WORD_W] = cpu_req_data;
    end

    //--------------------------------------------------------------------------
    // Storage write strobes
    //--------------------------------------------------------------------------
    logic hit_wr;
    logic miss_take;
    logic fill_en;

    assign hit_wr    = (state == COMPARE_TAG) && hit && cpu_req_rw;
    assign miss_take = (state == COMPARE_TAG) && !hit;
    assign fill_en   = (state == ALLOCATE) && mem_data_ready;

    //--------------------------------------------------------------------------
    // Next state and outputs
    //--------------------------------------------------------------------------
    always_comb begin
        next_state    = state;
        cpu_res_ready = 1'b0;
        cpu_res_data  = '0;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;

        // Outputs stay quiet while reset is asserted, whatever the state.
        if (rst) begin
            unique case (state)
                IDLE: begin
                    if (cpu_req_valid) begin
                        next_state = COMPARE_TAG;
                    end
                end

                COMPARE_TAG: begin
                    if (hit) begin
                        cpu_res_ready = 1'b1;
                        cpu_res_data  = hit_word;
                        next_state    = IDLE;
                    end else if (victim_dirty) begin
                        next_state = WRITE_BACK;
                    end else begin
                        next_state = ALLOCATE;
                    end
                end

                WRITE_BACK: begin
                    mem_req_valid = 1'b1;
                    mem_req_rw    = 1'b1;
                    mem_req_addr  = {vic_tag_q, req_idx, {OFF_W{1'b0}}};
                    mem_req_data  = vic_line_q;
                    if (mem_data_ready) begin
                        next_state = ALLOCATE;
                    end
                end

                ALLOCATE: begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
                    if (mem_data_ready) begin
                        next_state = COMPARE_TAG;
                    end
                end

                default: next_state = IDLE;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // State register and per-line control bits
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            state <= next_state;

            if (hit_wr) begin
                dirty_q[req_idx][hit_way] <= 1'b1;
            end

            if (fill_en) begin
                valid_q[req_idx][vic_way_q] <= 1'b1;
                dirty_q[req_idx][vic_way_q] <= 1'b0;
                // Round-robin only moves when the pointer's own way was used;
                // filling an invalid way elsewhere leaves it in place.
                if (vic_way_q == ptr_q[req_idx]) begin
                    ptr_q[req_idx] <= WAY_W'((int'(ptr_q[req_idx]) + 1) % WAYS);
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Tag / line storage and victim capture
    //--------------------------------------------------------------------------
    // NOTE: the data arrays carry no reset; a line is meaningless until its
    // valid bit is set, so clearing them would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (miss_take) begin
                vic_way_q  <= victim_way;
                vic_tag_q  <= tag_q[req_idx][victim_way];
                vic_line_q <= line_q[req_idx][victim_way];
            end

            if (hit_wr) begin
                line_q[req_idx][hit_way] <= merged_line;
            end

            if (fill_en) begin
                line_q[req_idx][vic_way_q] <= mem_data_data;
                tag_q[req_idx][vic_way_q]  <= req_tag;
            end
        end
    end

`ifdef CACHE_STATS_EN
    //--------------------------------------------------------------------------
    // Statistics counters (saturating)
    //--------------------------------------------------------------------------
    logic [31:0] hits_q;
    logic [31:0] misses_q;
    logic [31:0] wbs_q;
    logic        after_fill_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hits_q       <= '0;
            misses_q     <= '0;
            wbs_q        <= '0;
            after_fill_q <= 1'b0;
        end else begin
            // A fill is always followed directly by its completing compare,
            // which must not be counted as a second (hit) event.
            after_fill_q <= fill_en;
            if (state == COMPARE_TAG) begin
                if (hit) begin
                    if (!after_fill_q && (hits_q != '1)) begin
                        hits_q <= hits_q + 32'd1;
                    end
                end else begin
                    if (misses_q != '1) begin
                        misses_q <= misses_q + 32'd1;
                    end
                    if (victim_dirty && (wbs_q != '1)) begin
                        wbs_q <= wbs_q + 32'd1;
                    end
                end
            end
        end
    end

    assign stat_hits       = hits_q;
    assign stat_misses     = misses_q;
    assign stat_writebacks = wbs_q;
`endif

endmodule

// File: tb/tb_sa_cache_fsm.sv
//------------------------------------------------------------------------------
// tb_sa_cache_fsm
//
// Self-checking bench for sa_cache_fsm with default geometry (2-way, 1024
// sets, 4-word lines). A behavioural cache model predicts the memory traffic
// and read data of every access; expectations are queued at issue time and a
// separate monitor compares them when the DUT presents a response. Directed
// accesses cover cold fill, hits, write merge, two-way coexistence, dirty
// eviction, round-robin replacement and reset during a fill; randomized
// accesses over a few conflicting sets follow.
//------------------------------------------------------------------------------
module tb_sa_cache_fsm;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int WORDS  = 4;
    localparam int SETS   = 1024;
    localparam int WAYS   = 2;
    localparam int LINE_W = WORD_W * WORDS;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [WORD_W-1:0] cpu_req_data;
    logic              cpu_req_rw;
    logic              cpu_req_valid;
    logic [WORD_W-1:0] cpu_res_data;
    logic              cpu_res_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_data;
    logic              mem_req_rw;
    logic              mem_req_valid;
    logic [LINE_W-1:0] mem_data_data;
    logic              mem_data_ready;
`ifdef CACHE_STATS_EN
    logic [31:0]       stat_hits;
    logic [31:0]       stat_misses;
    logic [31:0]       stat_writebacks;
`endif

    sa_cache_fsm #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .WORDS(WORDS), .SETS(SETS), .WAYS(WAYS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_data   (cpu_req_data),
        .cpu_req_rw     (cpu_req_rw),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_res_data   (cpu_res_data),
        .cpu_res_ready  (cpu_res_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_rw     (mem_req_rw),
        .mem_req_valid  (mem_req_valid),
        .mem_data_data  (mem_data_data),
`ifdef CACHE_STATS_EN
        .stat_hits      (stat_hits),
        .stat_misses    (stat_misses),
        .stat_writebacks(stat_writebacks),
`endif
        .mem_data_ready (mem_data_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    //--------------------------------------------------------------------------
    // Scoreboard bookkeeping
    //--------------------------------------------------------------------------
    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } mem_exp_t;

    typedef struct {
        bit                chk;
        logic [WORD_W-1:0] data;
    } cpu_exp_t;

    mem_exp_t exp_mem[$];
    cpu_exp_t exp_cpu[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    //--------------------------------------------------------------------------
    // External memory device
    //--------------------------------------------------------------------------
    logic [LINE_W-1:0] mem_store [logic [ADDR_W-1:0]];
    bit                mem_stall    = 1'b0;
    bit                mem_lat_rand = 1'b0;
    logic [ADDR_W-1:0] last_wb_addr = '0;
    logic [LINE_W-1:0] last_wb_data = '0;
    int                wait_left;

    function automatic logic [LINE_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return {a ^ 32'h5A00_0003, a ^ 32'h5A00_0002, a ^ 32'h5A00_0001, a ^ 32'h5A00_0000};
    endfunction

    initial begin
        mem_data_ready = 1'b0;
        mem_data_data  = '0;
        wait_left      = -1;
        forever begin
            @(negedge clk);
            mem_data_ready = 1'b0;
            if (!rst || !mem_req_valid || mem_stall) begin
                wait_left = -1;
            end else begin
                if (wait_left < 0) wait_left = mem_lat_rand ? int'($urandom_range(0, 3)) : 0;
                if (wait_left == 0) begin
                    if (mem_req_rw) begin
                        mem_store[mem_req_addr] = mem_req_data;
                        last_wb_addr = mem_req_addr;
                        last_wb_data = mem_req_data;
                    end else begin
                        mem_data_data = mem_read(mem_req_addr);
                    end
                    mem_data_ready = 1'b1;
                    wait_left = -1;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Reference cache model: per-set ways with valid/dirty/tag/line and a
    // round-robin pointer, updated once per access from the replacement rules.
    //--------------------------------------------------------------------------
    bit                m_valid [SETS][WAYS];
    bit                m_dirty [SETS][WAYS];
    int unsigned       m_tag   [SETS][WAYS];
    logic [LINE_W-1:0] m_line  [SETS][WAYS];
    int                m_ptr   [SETS];
    int                n_hits, n_misses, n_wbs;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
        n_hits = 0;
        n_misses = 0;
        n_wbs = 0;
    endtask

    task automatic model_access(input logic [ADDR_W-1:0] addr, input bit rw,
                                input logic [WORD_W-1:0] wdata);
        int          s;
        int          wd;
        int          way;
        int unsigned t;
        mem_exp_t    me;
        cpu_exp_t    ce;
        s   = int'((addr >> 4) % SETS);
        wd  = int'((addr >> 2) % WORDS);
        t   = addr >> 14;
        way = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) way = w;
        if (way >= 0) begin
            n_hits++;
        end else begin
            n_misses++;
            for (int w = 0; w < WAYS; w++)
                if (!m_valid[s][w] && way < 0) way = w;
            if (way < 0) way = m_ptr[s];
            if (way == m_ptr[s]) m_ptr[s] = (m_ptr[s] + 1) % WAYS;
            if (m_valid[s][way] && m_dirty[s][way]) begin
                n_wbs++;
                me.rw   = 1'b1;
                me.addr = (m_tag[s][way] << 14) | (s << 4);
                me.data = m_line[s][way];
                exp_mem.push_back(me);
            end
            me.rw   = 1'b0;
            me.addr = addr & ~32'hF;
            me.data = '0;
            exp_mem.push_back(me);
            m_line[s][way]  = mem_read(addr & ~32'hF);
            m_valid[s][way] = 1'b1;
            m_dirty[s][way] = 1'b0;
            m_tag[s][way]   = t;
        end
        ce.chk  = !rw;
        ce.data = m_line[s][way][wd*WORD_W +: WORD_W];
        exp_cpu.push_back(ce);
        if (rw) begin
            m_line[s][way][wd*WORD_W +: WORD_W] = wdata;
            m_dirty[s][way] = 1'b1;
        end
    endtask

    //--------------------------------------------------------------------------
    // Monitor: compares memory handshakes and CPU completions with the queues
    //--------------------------------------------------------------------------
    initial begin
        mem_exp_t me;
        cpu_exp_t ce;
        forever begin
            @(negedge clk);
            #2;
            if (rst && mem_req_valid && mem_data_ready) begin
                check("mem_req_expected", exp_mem.size() != 0, 1'b1);
                if (exp_mem.size() != 0) begin
                    me = exp_mem.pop_front();
                    check("mem_req_rw", mem_req_rw, me.rw);
                    check("mem_req_addr", mem_req_addr, me.addr);
                    if (me.rw) check("mem_wb_data", mem_req_data, me.data);
                end
            end
            if (rst && cpu_res_ready) begin
                check("cpu_res_expected", exp_cpu.size() != 0, 1'b1);
                if (exp_cpu.size() != 0) begin
                    ce = exp_cpu.pop_front();
                    if (ce.chk) check("cpu_res_data", cpu_res_data, ce.data);
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // CPU driver: one blocking access; latency counts clock edges from the
    // edge that first sees valid up to and including the completion edge.
    //--------------------------------------------------------------------------
    task automatic cpu_access(input logic [ADDR_W-1:0] addr, input bit rw,
                              input logic [WORD_W-1:0] wdata,
                              output logic [WORD_W-1:0] rdata,
                              output int lat, output int mem_cyc);
        bit done;
        model_access(addr, rw, wdata);
        @(negedge clk);
        cpu_req_addr  = addr;
        cpu_req_rw    = rw;
        cpu_req_data  = wdata;
        cpu_req_valid = 1'b1;
        lat     = 0;
        mem_cyc = 0;
        rdata   = '0;
        done    = 1'b0;
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
            if (mem_req_valid) mem_cyc++;
            if (cpu_res_ready) begin
                rdata = cpu_res_data;
                done  = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL cpu_timeout: no cpu_res_ready within 300 cycles, addr 0x%0h", addr);
            finish_run();
        end
        lat = lat + 1;
        @(negedge clk);
        cpu_req_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_run();
    end

    //--------------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------------
    logic [WORD_W-1:0] rd;
    int                lat;
    int                mcyc;
    int                n;

    initial begin
        rst           = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_data  = '0;
        cpu_req_rw    = 1'b0;
        cpu_req_valid = 1'b0;
        model_reset();
        mem_store[32'h0000_1000] = 128'h4444_4444_3333_3333_2222_2222_1111_1111;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cpu_res_ready", cpu_res_ready, 1'b0);
        check("rst_cpu_res_data", cpu_res_data, '0);
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_mem_req_rw", mem_req_rw, 1'b0);
        check("rst_mem_req_addr", mem_req_addr, '0);
        check("rst_mem_req_data", mem_req_data, '0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_mem_req_valid", mem_req_valid, 1'b0);
        check("idle_cpu_res_ready", cpu_res_ready, 1'b0);

        // Cold read with 1-cycle memory response
        cpu_access(32'h0000_1004, 1'b0, '0, rd, lat, mcyc);
        check("cold_read_data", rd, 32'h2222_2222);
        check("cold_read_latency", lat, 4);
        check("cold_read_mem_cycles", mcyc, 1);

        // Read hit in the same line
        cpu_access(32'h0000_1008, 1'b0, '0, rd, lat, mcyc);
        check("hit_read_data", rd, 32'h3333_3333);
        check("hit_read_latency", lat, 2);
        check("hit_read_mem_cycles", mcyc, 0);

        // Write hit then read back
        cpu_access(32'h0000_1000, 1'b1, 32'hDEAD_BEEF, rd, lat, mcyc);
        check("write_hit_latency", lat, 2);
        cpu_access(32'h0000_1000, 1'b0, '0, rd, lat, mcyc);
        check("write_readback", rd, 32'hDEAD_BEEF);

        // Second way in set 0x100; both lines then hit
        cpu_access(32'h0000_5000, 1'b0, '0, rd, lat, mcyc);
        check("way1_fill_latency", lat, 4);
        cpu_access(32'h0000_1000, 1'b0, '0, rd, lat, mcyc);
        check("coexist_a_mem_cycles", mcyc, 0);
        cpu_access(32'h0000_5004, 1'b0, '0, rd, lat, mcyc);
        check("coexist_b_mem_cycles", mcyc, 0);

        // Dirty eviction of 0x1000 by 0x9000
        cpu_access(32'h0000_9000, 1'b0, '0, rd, lat, mcyc);
        check("evict_wb_addr", last_wb_addr, 32'h0000_1000);
        check("evict_wb_word0", last_wb_data[31:0], 32'hDEAD_BEEF);
        check("evict_latency", lat, 5);
        check("evict_mem_cycles", mcyc, 2);

        // Pointer now selects way 1: 0xD000 replaces 0x5000, 0x9000 survives
        cpu_access(32'h0000_D000, 1'b0, '0, rd, lat, mcyc);
        check("rr_clean_mem_cycles", mcyc, 1);
        cpu_access(32'h0000_9004, 1'b0, '0, rd, lat, mcyc);
        check("rr_survivor_mem_cycles", mcyc, 0);

        // Reset in the middle of an ALLOCATE
        mem_stall = 1'b1;
        @(negedge clk);
        cpu_req_addr  = 32'h0000_1000;
        cpu_req_rw    = 1'b0;
        cpu_req_valid = 1'b1;
        n = 0;
        while (!mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midrst_alloc_valid", mem_req_valid, 1'b1);
        check("midrst_alloc_rw", mem_req_rw, 1'b0);
        check("midrst_alloc_addr", mem_req_addr, 32'h0000_1000);
        rst           = 1'b0;
        cpu_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_mem_req_valid", mem_req_valid, 1'b0);
        check("midrst_cpu_res_ready", cpu_res_ready, 1'b0);
        exp_mem.delete();
        exp_cpu.delete();
        model_reset();
        mem_stall = 1'b0;
        cpu_access(32'h0000_1000, 1'b0, '0, rd, lat, mcyc);
        check("post_rst_miss_mem_cycles", mcyc, 1);
        check("post_rst_data", rd, 32'hDEAD_BEEF);

        // Randomized traffic over three sets and five tags, random latency
        mem_lat_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [ADDR_W-1:0] a;
            int                idx_sel;
            int                idx;
            idx_sel = int'($urandom_range(0, 2));
            idx = (idx_sel == 0) ? 32'h100 : (idx_sel == 1) ? 32'h101 : 32'h3FF;
            a = ($urandom_range(0, 4) << 14) | (idx << 4) | ($urandom_range(0, 3) << 2);
            cpu_access(a, 1'($urandom_range(0, 1)), $urandom, rd, lat, mcyc);
        end

        repeat (3) @(negedge clk);
        check("exp_mem_drained", exp_mem.size(), 0);
        check("exp_cpu_drained", exp_cpu.size(), 0);
`ifdef CACHE_STATS_EN
        check("stat_hits", stat_hits, n_hits);
        check("stat_misses", stat_misses, n_misses);
        check("stat_writebacks", stat_writebacks, n_wbs);
`endif
        finish_run();
    end

endmodule

// File: doc/sa_cache_fsm.md
Name: sa_cache_fsm

Overview:
- Parametrised successor to the direct-mapped cache controller: an N-way set-associative, write-back, write-allocate cache controller with internal tag/data storage.
- Sits between the CPU request port and the memory controller.
- Adds associativity, per-set round-robin victim selection, line-aligned memory addressing and a blocking CPU handshake.
- Uses the same four-state compare/allocate/write-back flow.

Parameters:
- ADDR_W, 32, CPU/memory byte address width.
- WORD_W, 32, CPU data word width.
- WORDS, 4, words per cache line (power of 2); LINE_W = WORD_W*WORDS.
- SETS, 1024, number of sets (power of 2); IDX_W = log2(SETS).
- WAYS, 2, associativity (power of 2, 1..8); WAYS=1 degenerates to direct-mapped.
- Derived: OFF_W = log2(WORDS)+log2(WORD_W/8); TAG_W = ADDR_W-IDX_W-OFF_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- cpu_req_addr  in  ADDR_W  CPU byte address.
- cpu_req_data  in  WORD_W  CPU write data.
- cpu_req_rw  in  1  1=write, 0=read.
- cpu_req_valid  in  1  request valid; CPU holds all cpu_req_* stable until cpu_res_ready.
- cpu_res_data  out  WORD_W  read data, valid while cpu_res_ready=1.
- cpu_res_ready  out  1  one-cycle completion pulse.
- mem_req_addr  out  ADDR_W  line-aligned memory address (offset bits 0).
- mem_req_data  out  LINE_W  write-back line.
- mem_req_rw  out  1  1=write-back, 0=line fill.
- mem_req_valid  out  1  memory request valid.
- mem_data_data  in  LINE_W  fill data.
- mem_data_ready  in  1  memory completion, 1 cycle.

Behaviour:
- Address split: tag=addr[ADDR_W-1:IDX_W+OFF_W], index=addr[IDX_W+OFF_W-1:OFF_W], word=addr[OFF_W-1:log2(WORD_W/8)].
- Storage per set/way: valid, dirty, tag, line. Per set: victim pointer, log2(WAYS) bits. Storage reads are combinational; writes take effect on the clock edge.
- Reset (rst=0 at edge): state=IDLE; all valid, dirty and victim pointers cleared. Line data is not cleared.
- Outputs are combinational from state and storage. While in reset and in IDLE: cpu_res_ready=0, cpu_res_data=0, mem_req_valid=0, mem_req_rw=0, mem_req_addr=0, mem_req_data=0.
- IDLE: cpu_req_valid=1 -> COMPARE_TAG.
- COMPARE_TAG hit (any way with valid=1 and tag match; at most one can match):
  - cpu_res_ready=1 for this cycle; cpu_res_data = selected word of the hit way.
  - On write: the word is merged into the line and dirty=1.
  - -> IDLE. Hit latency: 2 cycles from the valid edge seen in IDLE.
- COMPARE_TAG miss, victim selection: lowest-index invalid way; if none, the set's victim pointer.
  - Victim clean or invalid -> ALLOCATE.
  - Victim valid and dirty -> WRITE_BACK; latch victim way, tag and line.
- WRITE_BACK: mem_req_valid=1, rw=1, addr={victim tag, index, 0}, data=victim line. Held until mem_data_ready=1, then -> ALLOCATE.
- ALLOCATE: mem_req_valid=1, rw=0, addr={req tag, index, 0}. On mem_data_ready=1:
  - line=mem_data_data, tag=req tag, valid=1, dirty=0.
  - Victim pointer advances modulo WAYS only if the victim way was the pointer way.
  - -> COMPARE_TAG, which then hits and completes the access (write merge included).
- mem_data_ready outside WRITE_BACK/ALLOCATE: ignored.
- cpu_req_valid during COMPARE_TAG/WRITE_BACK/ALLOCATE: not re-sampled. Only one outstanding request.
- Reset mid-transaction: the transaction is dropped; mem_req_valid=0 from the cycle after the reset edge; dirty data is lost.
- Back-to-back: a new request is seen at the earliest in the IDLE cycle after cpu_res_ready.

Optional Feature:
- CACHE_STATS_EN defined:
  - Adds outputs stat_hits, stat_misses, stat_writebacks, each 32 bits, saturating, cleared by rst.
  - Counted at the COMPARE_TAG decision (a hit after a fill counts as a miss only, not a hit) and on WRITE_BACK entry.
- CACHE_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.

Test Plan (defaults):
- Cold read 0x0000_1004:
  - ALLOCATE request with mem_req_addr=0x0000_1000, rw=0.
  - Respond with line 0x4444_4444_3333_3333_2222_2222_1111_1111 -> cpu_res_data=0x2222_2222; total 4 cycles with a 1-cycle memory response.
- Read hit at 0x0000_1008 after the fill -> cpu_res_ready exactly 2 cycles after valid, data=0x3333_3333, no mem_req_valid.
- Write 0xDEAD_BEEF to 0x0000_1000 (hit) -> dirty=1; subsequent read returns 0xDEAD_BEEF.
- Two-way coexistence: fill 0x0000_1000 and 0x0000_5000 (same index 0x100) -> both hit afterwards, no memory traffic.
- Dirty eviction:
  - After the above, read 0x0000_9000 -> WRITE_BACK with addr=0x0000_1000, rw=1, data containing 0xDEAD_BEEF.
  - Then ALLOCATE with addr=0x0000_9000.
  - Victim pointer of set 0x100 = 1 afterwards.
- Reset mid-ALLOCATE (rst=0 for 1 cycle) -> IDLE, mem_req_valid=0 next cycle; re-read of 0x0000_1000 misses.
